// File: rtl/ssd_pkg.sv
// Shared constants and the hex-to-segment decode for the seven-segment scan controller.
package ssd_pkg;

  localparam int unsigned MAX_DIGITS = 8;

  // Cathodes and anodes are active-low, so "all ones" is dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = {MAX_DIGITS{1'b1}};

  // Returns active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg} for one hex nibble.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_tick_gen.sv
// Free-running W-bit counter; tick_o marks the all-ones (wrap) state, msb_o is the top bit.
module ssd_tick_gen #(
  parameter int unsigned W = 18
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o,
  output logic msb_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    tick_o = &cnt_q;
    msb_o  = cnt_q[W-1];
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// N-digit multiplexed seven-segment driver with frame-synchronous staged updates.
// Optional build macro: SSD_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned SCAN_CNT_W  = 18,
  parameter int unsigned BLINK_CNT_W = 26,
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    load,
  output logic                    load_ack,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [6:0]              cathodes,
  output logic                    dp_n,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam logic [NUM_DIGITS-1:0] AnOff = ANODE_OFF[NUM_DIGITS-1:0];

  logic scan_tick, blink_off, unused_scan_msb, unused_blink_wrap;

  ssd_tick_gen #(.W(SCAN_CNT_W)) u_scan_prescaler (
    .clk_i  (Clk),
    .rst_i  (reset),
    .tick_o (scan_tick),
    .msb_o  (unused_scan_msb)
  );

  ssd_tick_gen #(.W(BLINK_CNT_W)) u_blink_counter (
    .clk_i  (Clk),
    .rst_i  (reset),
    .tick_o (unused_blink_wrap),
    .msb_o  (blink_off)
  );

  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    pend_q, pend_d;
  logic                    ack_q, ack_d;
  logic [4*NUM_DIGITS-1:0] stg_dig_q, stg_dig_d, act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   stg_blank_q, stg_blank_d, act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]   stg_blink_q, stg_blink_d, act_blink_q, act_blink_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              ca_q, ca_d;
  logic                    dpn_q, dpn_d;

  logic                    frame_tick, commit;
  logic [NUM_DIGITS-1:0]   lz_blank, onehot;
  logic                    off;

  // Staging, commit and scan position.
  always_comb begin
    frame_tick = scan_tick & (idx_q == IDX_W'(NUM_DIGITS - 1));
    commit     = frame_tick & (pend_q | load);

    idx_d = idx_q;
    if (scan_tick) begin
      idx_d = frame_tick ? '0 : idx_q + IDX_W'(1);
    end

    stg_dig_d   = stg_dig_q;
    stg_dp_d    = stg_dp_q;
    stg_blank_d = stg_blank_q;
    stg_blink_d = stg_blink_q;
    if (load) begin
      stg_dig_d   = digits_in;
      stg_dp_d    = dp_in;
      stg_blank_d = blank_in;
      stg_blink_d = blink_in;
    end

    // A load landing on the commit tick bypasses staging straight into the active set.
    act_dig_d   = act_dig_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    act_blink_d = act_blink_q;
    if (commit) begin
      act_dig_d   = load ? digits_in : stg_dig_q;
      act_dp_d    = load ? dp_in     : stg_dp_q;
      act_blank_d = load ? blank_in  : stg_blank_q;
      act_blink_d = load ? blink_in  : stg_blink_q;
    end

    pend_d = pend_q;
    if (frame_tick) begin
      pend_d = 1'b0;
    end else if (load) begin
      pend_d = 1'b1;
    end

    ack_d = commit;
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  logic zero_above;

  always_comb begin
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above & (act_dig_q[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_above;
    end
  end
`else
  always_comb begin
    lz_blank = '0;
  end
`endif

  // Output decode for the digit currently being scanned.
  always_comb begin
    onehot        = '0;
    onehot[idx_q] = 1'b1;
    off = act_blank_q[idx_q] | (act_blink_q[idx_q] & blink_off) | lz_blank[idx_q];
    if (off) begin
      an_d  = AnOff;
      ca_d  = SEG_BLANK;
      dpn_d = 1'b1;
    end else begin
      an_d  = ~onehot;
      ca_d  = hex2seg(act_dig_q[{idx_q, 2'b00} +: 4]);
      dpn_d = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      pend_q      <= 1'b0;
      ack_q       <= 1'b0;
      stg_dig_q   <= '0;
      stg_dp_q    <= '0;
      stg_blank_q <= '1;
      stg_blink_q <= '0;
      act_dig_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '1;
      act_blink_q <= '0;
      an_q        <= AnOff;
      ca_q        <= SEG_BLANK;
      dpn_q       <= 1'b1;
    end else begin
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      ack_q       <= ack_d;
      stg_dig_q   <= stg_dig_d;
      stg_dp_q    <= stg_dp_d;
      stg_blank_q <= stg_blank_d;
      stg_blink_q <= stg_blink_d;
      act_dig_q   <= act_dig_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      act_blink_q <= act_blink_d;
      an_q        <= an_d;
      ca_q        <= ca_d;
      dpn_q       <= dpn_d;
    end
  end

  always_comb begin
    load_ack  = ack_q;
    anodes    = an_q;
    cathodes  = ca_q;
    dp_n      = dpn_q;
    digit_idx = idx_q;
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Randomised bench for ssd_scan_ctrl (4 digits, fast prescaler and blink) against a cycle-count model.
module tb_ssd_scan_ctrl;

  logic        Clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, blank_in, blink_in;
  logic        load;
  logic        load_ack;
  logic [3:0]  anodes;
  logic [6:0]  cathodes;
  logic        dp_n;
  logic [1:0]  digit_idx;

  int n_cmp = 0;
  int n_bad = 0;

  ssd_scan_ctrl #(
    .NUM_DIGITS  (4),
    .SCAN_CNT_W  (2),
    .BLINK_CNT_W (6)
  ) dut (
    .Clk       (Clk),
    .reset     (reset),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .blank_in  (blank_in),
    .blink_in  (blink_in),
    .load      (load),
    .load_ack  (load_ack),
    .anodes    (anodes),
    .cathodes  (cathodes),
    .dp_n      (dp_n),
    .digit_idx (digit_idx)
  );

  always #5 Clk = ~Clk;

  // Reference model: everything derives from the number of clocks since reset.
  // 4 clocks per digit, 16 per frame, blink phase toggles every 32 clocks.
  int unsigned cyc;
  logic [15:0] m_stg_dig, m_act_dig;
  logic [3:0]  m_stg_dp, m_act_dp, m_stg_bl, m_act_bl, m_stg_bk, m_act_bk;
  logic        m_pend;
  logic [11:0] e_out;
  logic        e_ack;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16];
    t[0]  = 7'b0000001; t[1]  = 7'b1001111; t[2]  = 7'b0010010; t[3]  = 7'b0000110;
    t[4]  = 7'b1001100; t[5]  = 7'b0100100; t[6]  = 7'b0100000; t[7]  = 7'b0001111;
    t[8]  = 7'b0000000; t[9]  = 7'b0000100; t[10] = 7'b0001000; t[11] = 7'b1100000;
    t[12] = 7'b0110001; t[13] = 7'b1000010; t[14] = 7'b0110000; t[15] = 7'b0111000;
    return t[n];
  endfunction

  function automatic logic [11:0] model_out(input int unsigned c, input logic [15:0] dg,
                                            input logic [3:0] dp, input logic [3:0] bl,
                                            input logic [3:0] bk);
    int   d    = int'((c / 4) % 4);
    bit   boff = ((c / 32) % 2) == 1;
    bit   lz   = 1'b0;
    logic [3:0] nib = 4'((dg >> (4 * d)) & 16'hF);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    if (d >= 1) lz = ((dg >> (4 * d)) == 16'h0);
`endif
    if (bl[d] || (bk[d] && boff) || lz) return {4'hF, 7'h7F, 1'b1};
    return {~(4'b0001 << d), seg_of(nib), ~dp[d]};
  endfunction

  always @(posedge Clk or posedge reset) begin
    if (reset) begin
      cyc <= 0;
      m_stg_dig <= '0; m_act_dig <= '0;
      m_stg_dp  <= '0; m_act_dp  <= '0;
      m_stg_bl  <= '1; m_act_bl  <= '1;
      m_stg_bk  <= '0; m_act_bk  <= '0;
      m_pend    <= 1'b0;
      e_out     <= {4'hF, 7'h7F, 1'b1};
      e_ack     <= 1'b0;
    end else begin
      e_out <= model_out(cyc, m_act_dig, m_act_dp, m_act_bl, m_act_bk);
      e_ack <= (cyc % 16 == 15) && (m_pend || load);
      if (cyc % 16 == 15) begin
        if (load) begin
          m_act_dig <= digits_in; m_act_dp <= dp_in; m_act_bl <= blank_in; m_act_bk <= blink_in;
        end else if (m_pend) begin
          m_act_dig <= m_stg_dig; m_act_dp <= m_stg_dp; m_act_bl <= m_stg_bl; m_act_bk <= m_stg_bk;
        end
        m_pend <= 1'b0;
      end else if (load) begin
        m_pend <= 1'b1;
      end
      if (load) begin
        m_stg_dig <= digits_in; m_stg_dp <= dp_in; m_stg_bl <= blank_in; m_stg_bk <= blink_in;
      end
      cyc <= cyc + 1;
    end
  end

  wire [14:0] obs  = {anodes, cathodes, dp_n, load_ack, digit_idx};
  wire [14:0] expv = {e_out, e_ack, 2'((cyc / 4) % 4)};
  localparam logic [14:0] RstObs = {4'hF, 7'h7F, 1'b1, 1'b0, 2'b00};

  task automatic set_in(input logic [15:0] dg, input logic [3:0] dp, input logic [3:0] bl,
                        input logic [3:0] bk);
    digits_in = dg; dp_in = dp; blank_in = bl; blink_in = bk;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0;
    set_in(16'h0, 4'h0, 4'h0, 4'h0);
    repeat (3) @(negedge Clk);
    n_cmp++;
    if (obs !== RstObs) begin
      n_bad++; $display("FAIL reset_hold obs=%h req=%h", obs, RstObs);
    end
    reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      n_cmp++;
      if (obs !== expv || {anodes, cathodes, dp_n} !== {4'hF, 7'h7F, 1'b1}) begin
        n_bad++; $display("FAIL reset_idle[%0d] obs=%h req=%h", i, obs, expv);
      end
    end
  endtask

  task automatic test_basic_load();
    int acks = 0;
    set_in(16'h1234, 4'h0, 4'h0, 4'h0);
    load = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge Clk);
      load = 1'b0;
      acks += int'(load_ack);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL basic[%0d] obs=%h req=%h", i, obs, expv);
      end
    end
    n_cmp++;
    if (acks !== 1) begin
      n_bad++; $display("FAIL basic_ack_count got=%0d req=1", acks);
    end
  endtask

  task automatic test_double_load();
    int acks = 0;
    while (cyc % 16 != 1) begin
      @(negedge Clk);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL double_sync obs=%h req=%h", obs, expv);
      end
    end
    set_in(16'h1111, 4'h0, 4'h0, 4'h0);
    load = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge Clk);
      load = (i == 2);
      if (i == 2) set_in(16'h2222, 4'h0, 4'h0, 4'h0);
      acks += int'(load_ack);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL double[%0d] obs=%h req=%h", i, obs, expv);
      end
      if (i >= 20 && anodes != 4'hF && cathodes !== 7'b0010010) begin
        n_cmp++; n_bad++; $display("FAIL double_show[%0d] cath=%b req=0010010", i, cathodes);
      end
    end
    n_cmp++;
    if (acks !== 1) begin
      n_bad++; $display("FAIL double_ack_count got=%0d req=1", acks);
    end
  endtask

  task automatic test_commit_bypass();
    while (cyc % 16 != 15) begin
      @(negedge Clk);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL bypass_sync obs=%h req=%h", obs, expv);
      end
    end
    set_in(16'hABCD, 4'h5, 4'h0, 4'h0);
    load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
    n_cmp++;
    if (load_ack !== 1'b1) begin
      n_bad++; $display("FAIL bypass_ack got=%b req=1", load_ack);
    end
    for (int i = 0; i < 24; i++) begin
      @(negedge Clk);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL bypass[%0d] obs=%h req=%h", i, obs, expv);
      end
    end
  endtask

  task automatic test_blink();
    set_in(16'h9876, 4'h0, 4'h0, 4'b0100);
    load = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge Clk);
      load = 1'b0;
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL blink[%0d] obs=%h req=%h", i, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    while (cyc % 16 != 2) @(negedge Clk);
    set_in(16'h4321, 4'hF, 4'h0, 4'h0);
    load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
    @(negedge Clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== RstObs) begin
      n_bad++; $display("FAIL reset_mid obs=%h req=%h", obs, RstObs);
    end
    @(negedge Clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      acks += int'(load_ack);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL reset_mid[%0d] obs=%h req=%h", i, obs, expv);
      end
    end
    n_cmp++;
    if (acks !== 0) begin
      n_bad++; $display("FAIL reset_mid_ack got=%0d req=0", acks);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      @(negedge Clk);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL random[%0d] obs=%h req=%h", i, obs, expv);
      end
      load = ($urandom_range(0, 7) == 0);
      if (load) begin
        set_in(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
               4'($urandom));
      end
    end
    load = 1'b0;
  endtask

  task automatic test_leading_zero();
    set_in(16'h0005, 4'h0, 4'h0, 4'h0);
    load = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge Clk);
      load = 1'b0;
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL lz[%0d] obs=%h req=%h", i, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_double_load();
    test_commit_bypass();
    test_blink();
    test_reset_mid();
    test_random();
    test_leading_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
